// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op encodings, FSM state type and
// the shift-amount width helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor producing sum, unsigned carry/borrow and
// signed overflow for the ALU.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] sum,
    output logic                    carry,
    output logic                    overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Subtract as a + ~b + 1; carry-out of that sum is the inverted borrow.
    always_comb begin
        b_eff    = sub ? ~b : b;
        full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full[WIDTH-1:0];
        carry    = sub ? ~full[WIDTH] : full[WIDTH];
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts.
// Define ALU_ITER_BARREL_EN to make every shift complete in one cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result,
    output logic                    zero,
    output logic                    negative,
    output logic                    carry,
    output logic                    overflow
);

    localparam int SHW = shamt_width(WIDTH);

    state_t                  state;
    logic [SHW-1:0]          shamt;
    logic [SHW-1:0]          cnt;
    logic [3:0]              op_p0;
    logic [WIDTH-1:0]        sreg_p0;
    logic [WIDTH-1:0]        sreg_next;
    logic signed [WIDTH-1:0] as_sum;
    logic signed [WIDTH-1:0] imm_res;
    logic                    as_carry;
    logic                    as_ovf;
    logic                    imm_carry;
    logic                    imm_ovf;
    logic                    is_shift;
    logic                    accept;
    logic                    iterate;

    function automatic logic [WIDTH-1:0] shift_step(input logic [3:0] sop,
                                                    input logic [WIDTH-1:0] v);
        case (sop)
            OP_SLL:  return {v[WIDTH-2:0], 1'b0};
            OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return {1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    assign shamt    = b[SHW-1:0];
    assign accept   = start && (state != SHIFT);
    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef ALU_ITER_BARREL_EN
    assign iterate  = 1'b0;
`else
    assign iterate  = is_shift && (shamt != '0);
`endif
    assign sreg_next = shift_step(op_p0, sreg_p0);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (op == OP_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // Result of any op that completes in the accept cycle, straight from the inputs.
    always_comb begin
        imm_res   = '0;
        imm_carry = 1'b0;
        imm_ovf   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                imm_res   = as_sum;
                imm_carry = as_carry;
                imm_ovf   = as_ovf;
            end
            OP_AND:  imm_res = a & b;
            OP_OR:   imm_res = a | b;
            OP_XOR:  imm_res = a ^ b;
            OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
`ifdef ALU_ITER_BARREL_EN
            OP_SLL:  imm_res = a << shamt;
            OP_SRL:  imm_res = $signed($unsigned(a) >> shamt);
            OP_SRA:  imm_res = a >>> shamt;
`else
            OP_SLL, OP_SRL, OP_SRA: imm_res = a;
`endif
            default: imm_res = '0;
        endcase
    end

    // Control and architectural outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept && iterate) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= shamt;
                    end else if (accept) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= imm_res;
                        zero     <= (imm_res == '0);
                        negative <= imm_res[WIDTH-1];
                        carry    <= imm_carry;
                        overflow <= imm_ovf;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= sreg_next;
                        zero     <= (sreg_next == '0);
                        negative <= sreg_next[WIDTH-1];
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and one-bit-per-cycle shift datapath.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= op;
            sreg_p0 <= a;
        end else if (state == SHIFT) begin
            sreg_p0 <= sreg_next;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Randomised scoreboard bench for alu_iter against an arithmetic reference model.
module tb_alu_iter;

    typedef struct {
        logic [31:0] res;
        logic        z, n, c, v;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero, negative, carry, overflow;
    logic [31:0] result;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t q[$];
    exp_t last;

    alu_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, s;
        logic [32:0] u;
        int k;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        k  = int'(y[4:0]);
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 0; e.acc = 0;
        case (o)
            4'd0: begin
                u = {1'b0, x} + {1'b0, y};
                e.res = u[31:0];
                e.c = u[32];
                s = sx + sy;
                e.v = (s != longint'($signed(e.res)));
            end
            4'd1: begin
                e.res = x - y;
                e.c = (x < y);
                s = sx - sy;
                e.v = (s != longint'($signed(e.res)));
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'd6: e.res = (x < y) ? 32'd1 : 32'd0;
            4'd7: e.res = x << k;
            4'd8: e.res = x >> k;
            4'd9: e.res = 32'(sx >>> k);
            default: e.res = '0;
        endcase
`ifndef ALU_ITER_BARREL_EN
        if (o >= 4'd7 && o <= 4'd9) e.lat = k;
`endif
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    // Shift in progress: the oldest pending op needs more cycles than have elapsed.
    function automatic bit model_busy();
        if (q.size() == 0) return 1'b0;
        return (cyc - q[0].acc) < q[0].lat;
    endfunction

    // Monitor: runs 1 time unit after each falling edge, after stimulus has pushed.
    initial begin
        exp_t e;
        last = '{res: 32'd0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, lat: 0, acc: 0};
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("flags_zncv", 64'({zero, negative, carry, overflow}),
                        64'({e.z, e.n, e.c, e.v}));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    last = e;
                end
            end else begin
                chk("hold", 64'({result, zero, negative, carry, overflow}),
                    64'({last.res, last.z, last.n, last.c, last.v}));
            end
            chk("busy", 64'(busy), 64'(model_busy()));
        end
    end

    // Issue one op from a falling edge; it is accepted on the next rising edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        e = model(o, x, y);
        e.acc = cyc;
        q.push_back(e);
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait for the scoreboard to drain; optionally throw ignored starts at a busy DUT.
    task automatic wait_idle(input bit poke);
        int n = 0;
        while (q.size() != 0 && n < 80) begin
            if (model_busy() && (poke || $urandom_range(0, 1) == 1)) begin
                start = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("drain", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corners [4];
        logic [31:0] x, y;
        corners[0] = 32'h0; corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000; corners[3] = 32'h7FFF_FFFF;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, result, zero, negative, carry, overflow}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(4'd0, 32'hFFFF_FFFF, 32'd1);        wait_idle(1'b0);
        issue(4'd1, 32'h8000_0000, 32'd1);        wait_idle(1'b0);
        issue(4'd1, 32'd1, 32'd2);                wait_idle(1'b0);
        issue(4'd9, 32'h8000_0000, 32'h0000_001F); wait_idle(1'b1);
        issue(4'd7, 32'd1, 32'h24);               wait_idle(1'b0);

        // Reset during the third shift cycle of a long SRL, with nonzero outputs held.
        issue(4'd1, 32'd1, 32'd2);                wait_idle(1'b0);
        issue(4'd8, 32'hF0, 32'd8);
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_outputs", 64'({busy, done, result, zero, negative, carry, overflow}), 64'd0);
        q.delete();
        last = '{res: 32'd0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, lat: 0, acc: 0};
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(4'd0, 32'd2, 32'd3);                wait_idle(1'b0);

        // start held high across two edges: SLT then SLTU back to back.
        begin
            exp_t e;
            start = 1'b1; op = 4'd5; a = 32'hFFFF_FFFF; b = 32'd1;
            @(posedge clk);
            @(negedge clk);
            e = model(4'd5, 32'hFFFF_FFFF, 32'd1); e.acc = cyc; q.push_back(e);
            op = 4'd6;
            @(posedge clk);
            @(negedge clk);
            e = model(4'd6, 32'hFFFF_FFFF, 32'd1); e.acc = cyc; q.push_back(e);
            start = 1'b0;
            wait_idle(1'b0);
        end

        issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0); wait_idle(1'b0);
        issue(4'd8, 32'hDEAD_BEEF, 32'hFFFF_FFE0);  wait_idle(1'b0);

        for (int i = 0; i < 150; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            issue(4'($urandom_range(0, 15)), x, y);
            wait_idle(1'b0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
